// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and state enums shared by the iterative ALU/MDU
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_ADD   = 4'd2,
    OP_XOR   = 4'd3,
    OP_SLL   = 4'd4,
    OP_SRL   = 4'd5,
    OP_SUB   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIV   = 4'd12,
    OP_DIVU  = 4'd13,
    OP_REM   = 4'd14,
    OP_REMU  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_e;

  function automatic logic is_iter_op(input alu_op_e op);
    return op inside {OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_mdu_iter_if.sv
// rtl/alu_mdu_iter_if.sv - operand/result handshake bundle of the EX-stage ALU
interface alu_mdu_iter_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, op, src_a, src_b, flush, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, op, src_a, src_b, flush, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - one-bit-per-cycle shift-add multiplier and restoring divider
module mdu_iter_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic            kill,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            last,
  output logic [XLEN-1:0] res
);

  localparam int CNTW = $clog2(XLEN) + 1;

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              sel_hi_q, sel_hi_d;
  logic              negate_q, negate_d;
  logic              force_ones_q, force_ones_d;

  logic              sgn, a_neg, b_neg, b_zero, q_bit;
  logic [XLEN-1:0]   a_mag, b_mag, raw;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;

  always_comb begin
    acc_d        = acc_q;
    opnd_d       = opnd_q;
    cnt_d        = cnt_q;
    is_div_d     = is_div_q;
    sel_hi_d     = sel_hi_q;
    negate_d     = negate_q;
    force_ones_d = force_ones_q;

    sgn    = (op == OP_DIV) | (op == OP_REM);
    a_neg  = sgn & src_a[XLEN-1];
    b_neg  = sgn & src_b[XLEN-1];
    a_mag  = a_neg ? -src_a : src_a;
    b_mag  = b_neg ? -src_b : src_b;
    b_zero = (src_b == '0);

    // acc holds {high partial product, multiplier} or {remainder, dividend/quotient}
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    q_bit     = ~div_diff[XLEN];

    if (kill) begin
      cnt_d = '0;
    end else if (start) begin
      is_div_d     = !((op == OP_MUL) | (op == OP_MULHU));
      sel_hi_d     = (op == OP_MULHU) | (op == OP_REM) | (op == OP_REMU);
      negate_d     = ((op == OP_DIV) & (a_neg ^ b_neg) & ~b_zero) | ((op == OP_REM) & a_neg);
      force_ones_d = ((op == OP_DIV) | (op == OP_DIVU)) & b_zero;
      acc_d        = {{XLEN{1'b0}}, a_mag};
      opnd_d       = b_mag;
      cnt_d        = '0;
    end else if (step) begin
      if (is_div_q) begin
        acc_d = {q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0], acc_q[XLEN-2:0], q_bit};
      end else begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end
      cnt_d = cnt_q + CNTW'(1);
    end

    // sign fix-up rides on the final step so it costs no extra cycle
    raw  = sel_hi_q ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
    res  = force_ones_q ? '1 : (negate_q ? -raw : raw);
    last = step & (cnt_q == CNTW'(XLEN-1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q        <= '0;
      opnd_q       <= '0;
      cnt_q        <= '0;
      is_div_q     <= 1'b0;
      sel_hi_q     <= 1'b0;
      negate_q     <= 1'b0;
      force_ones_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      opnd_q       <= opnd_d;
      cnt_q        <= cnt_d;
      is_div_q     <= is_div_d;
      sel_hi_q     <= sel_hi_d;
      negate_q     <= negate_d;
      force_ones_q <= force_ones_d;
    end
  end

endmodule

// File: rtl/alu_mdu_iter.sv
// rtl/alu_mdu_iter.sv - EX-stage ALU with registered output and iterative RV32M ops
module alu_mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = OP_W
) (
  input logic         clk,
  input logic         rst_n,
  alu_mdu_iter_if.slave bus
);

  localparam int SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;

  alu_op_e         op_in;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            in_ready_c, accept, iter_acc;
  logic            core_last;
  logic [XLEN-1:0] core_res;

  assign op_in = alu_op_e'(bus.op);
  assign shamt = bus.src_b[SHW-1:0];

  always_comb begin
    alu_res = bus.src_a;
    case (op_in)
      OP_AND:  alu_res = bus.src_a & bus.src_b;
      OP_OR:   alu_res = bus.src_a | bus.src_b;
      OP_XOR:  alu_res = bus.src_a ^ bus.src_b;
      OP_ADD:  alu_res = bus.src_a + bus.src_b;
      OP_SUB:  alu_res = bus.src_a - bus.src_b;
      OP_SLL:  alu_res = bus.src_a << shamt;
      OP_SRL:  alu_res = bus.src_a >> shamt;
      OP_SRA:  alu_res = $signed(bus.src_a) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.src_a < bus.src_b};
      default: alu_res = bus.src_a;
    endcase
  end

  assign in_ready_c = rst_n & ~bus.flush &
                      ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
  assign accept     = bus.in_valid & in_ready_c;
  assign iter_acc   = accept & is_iter_op(op_in);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && bus.out_ready) begin
          state_d = IDLE;
        end
        // a DONE-state accept coincides with the out transfer, so there is no bubble
        if (accept) begin
          if (is_iter_op(op_in)) begin
            state_d = ITER;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end
      end
      ITER: begin
        if (core_last) begin
          state_d  = DONE;
          result_d = core_res;
          zero_d   = (core_res == '0);
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d  = IDLE;
      result_d = result_q;
      zero_d   = zero_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (iter_acc),
    .step  (state_q == ITER),
    .kill  (bus.flush),
    .op    (op_in),
    .src_a (bus.src_a),
    .src_b (bus.src_b),
    .last  (core_last),
    .res   (core_res)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == ITER);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_mdu_iter.sv
// tb/tb_alu_mdu_iter.sv - randomized self-checking bench for alu_mdu_iter
module tb_alu_mdu_iter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_mdu_iter_if #(.XLEN(32), .OPW(4)) bus ();

  alu_mdu_iter #(.XLEN(32), .OPW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] ref_model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = {32'd0, a} * {32'd0, b};
    case (o)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return a << b[4:0];
      4'd5:  return a >> b[4:0];
      4'd6:  return a - b;
      4'd7:  return $signed(a) >>> b[4:0];
      4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issues one op with out_ready=1, scrambles inputs after accept, returns the result and timing.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat,
                        output int busy_n, output bit rdy_seen);
    bit got;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b; bus.out_ready = 1'b1;
    @(posedge clk);
    lat = 0; busy_n = 0; rdy_seen = 1'b0; got = 1'b0;
    for (int k = 1; k <= 100 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.in_valid = 1'b0; bus.op = 4'($urandom); bus.src_a = $urandom; bus.src_b = $urandom;
      end
      if (bus.out_valid) begin
        lat = k; got = 1'b1;
      end else begin
        if (bus.busy) busy_n++;
        if (bus.in_ready) rdy_seen = 1'b1;
      end
    end
    res = bus.result;
    z   = bus.zero;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus.op = '0; bus.src_a = '0; bus.src_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    total++; if (bus.zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b exp=0", bus.zero); end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = OP_ADD; bus.src_a = 32'h7FFF_FFFF; bus.src_b = 32'd1; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.result !== 32'h8000_0000 || bus.zero !== 1'b0) begin
      bad++; $display("FAIL b2b_add got v=%b r=%h z=%b exp v=1 r=80000000 z=0", bus.out_valid, bus.result, bus.zero); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", bus.in_ready); end
    bus.op = OP_SUB; bus.src_a = 32'd5; bus.src_b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd0 || bus.zero !== 1'b1) begin
      bad++; $display("FAIL b2b_sub got v=%b r=%h z=%b exp v=1 r=0 z=1", bus.out_valid, bus.result, bus.zero); end
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_single_cycle();
    logic [3:0]  dop [3] = '{OP_SRA, OP_SLT, OP_SLTU};
    logic [31:0] da  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] db  [3] = '{32'h0000_0024, 32'd1, 32'd1};
    logic [31:0] de  [3] = '{32'hF800_0000, 32'd1, 32'd0};
    logic [31:0] res, a, b, exp;
    logic [3:0]  o;
    logic        z;
    int          lat, bn;
    bit          rs;
    for (int i = 0; i < 3; i++) begin
      run_op(dop[i], da[i], db[i], res, z, lat, bn, rs);
      total++; if (res !== de[i] || lat !== 1) begin
        bad++; $display("FAIL single_directed[%0d] got r=%h lat=%0d exp r=%h lat=1", i, res, lat, de[i]); end
    end
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 9));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      exp = ref_model(o, a, b);
      run_op(o, a, b, res, z, lat, bn, rs);
      total++; if (res !== exp || z !== (exp == 0) || lat !== 1) begin
        bad++; $display("FAIL single_rand op=%0d a=%h b=%h got r=%h z=%b lat=%0d exp r=%h z=%b lat=1",
                        o, a, b, res, z, lat, exp, exp == 0); end
    end
  endtask

  task automatic test_mdu();
    logic [3:0]  dop [7] = '{OP_MULHU, OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_REM, OP_MUL};
    logic [31:0] da  [7] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'd3};
    logic [31:0] db  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd2, 32'd4};
    logic [31:0] de  [7] = '{32'hFFFF_FFFE, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'd12};
    logic [31:0] res, a, b, exp;
    logic [3:0]  o;
    logic        z;
    int          lat, bn;
    bit          rs;
    for (int i = 0; i < 7; i++) begin
      run_op(dop[i], da[i], db[i], res, z, lat, bn, rs);
      total++; if (res !== de[i] || z !== (de[i] == 0)) begin
        bad++; $display("FAIL mdu_directed[%0d] got r=%h z=%b exp r=%h", i, res, z, de[i]); end
      total++; if (lat !== 33 || bn !== 32 || rs !== 1'b0) begin
        bad++; $display("FAIL mdu_timing[%0d] got lat=%0d busy=%0d rdy=%b exp lat=33 busy=32 rdy=0", i, lat, bn, rs); end
    end
    for (int i = 0; i < 24; i++) begin
      o = 4'($urandom_range(10, 15));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      exp = ref_model(o, a, b);
      run_op(o, a, b, res, z, lat, bn, rs);
      total++; if (res !== exp || z !== (exp == 0) || lat !== 33) begin
        bad++; $display("FAIL mdu_rand op=%0d a=%h b=%h got r=%h z=%b lat=%0d exp r=%h lat=33",
                        o, a, b, res, z, lat, exp); end
    end
  endtask

  task automatic test_flush();
    int ghost;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = OP_DIV; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.out_ready = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL flush_busy_before got=%b exp=1", bus.busy); end
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.op = OP_ADD; bus.src_a = 32'd100; bus.src_b = 32'd100;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready); end
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL flush_state got v=%b busy=%b exp v=0 busy=0", bus.out_valid, bus.busy); end
    bus.op = OP_ADD; bus.src_a = 32'd1; bus.src_b = 32'd2;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd3) begin
      bad++; $display("FAIL flush_next_add got v=%b r=%h exp v=1 r=3", bus.out_valid, bus.result); end
    @(posedge clk);
    ghost = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_valid) ghost++;
    end
    total++; if (ghost !== 0) begin bad++; $display("FAIL flush_ghost_result got=%0d exp=0", ghost); end
  endtask

  task automatic test_hold();
    int lat;
    int held_bad;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = OP_MUL; bus.src_a = 32'd3; bus.src_b = 32'd4; bus.out_ready = 1'b0;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.out_valid) lat = k;
    end
    total++; if (lat !== 33) begin bad++; $display("FAIL hold_latency got=%0d exp=33", lat); end
    held_bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.out_valid !== 1'b1 || bus.result !== 32'd12 || bus.zero !== 1'b0 || bus.in_ready !== 1'b0) held_bad++;
      bus.in_valid = 1'b1; bus.op = OP_ADD; bus.src_a = $urandom; bus.src_b = $urandom;
      @(posedge clk);
      @(negedge clk);
    end
    total++; if (held_bad !== 0) begin bad++; $display("FAIL hold_stable got=%0d bad cycles exp=0", held_bad); end
    total++; if (bus.result !== 32'd12) begin bad++; $display("FAIL hold_result got=%h exp=c", bus.result); end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL hold_release got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    int ghost;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd1000; bus.src_b = 32'd3; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b exp=1", bus.busy); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'd0 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL rstmid_state got v=%b busy=%b r=%h rdy=%b exp 0 0 0 0",
                      bus.out_valid, bus.busy, bus.result, bus.in_ready); end
    rst_n = 1'b1;
    ghost = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_valid) ghost++;
    end
    total++; if (ghost !== 0) begin bad++; $display("FAIL rstmid_ghost got=%0d exp=0", ghost); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_cycle();
    test_mdu();
    test_flush();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
